// File: rtl/mem_arbiter_mp.sv
// mem_arbiter_mp: N requesters share one single-port memory through a round-robin arbiter.
// Each client can read or write, and can lock the arbiter to hold its grant for bursts.
// Reads have one cycle of latency; out-of-range accesses pulse err one cycle after the grant.
// Optional build macro MEM_ARB_STATS_EN adds per-client saturating grant counters (grant_cnt).
module mem_arbiter_mp #(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          we,
    input  logic [N_CLIENTS-1:0]          lock,
    input  logic [N_CLIENTS*ADDR_W-1:0]   addr,
    input  logic [N_CLIENTS*DATA_W-1:0]   wdata,
    output logic [N_CLIENTS-1:0]          gnt,
    output logic [N_CLIENTS-1:0]          rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic [N_CLIENTS-1:0]          err
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [N_CLIENTS*16-1:0]       grant_cnt
`endif
);

    localparam int unsigned IDX_W  = $clog2(N_CLIENTS);
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        StArb,
        StLocked
    } arb_state_e;

    arb_state_e           r_state;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_ptr;
    logic [N_CLIENTS-1:0] r_rvalid;
    logic [N_CLIENTS-1:0] r_err;
    logic [DATA_W-1:0]    r_rdata;
    logic [DATA_W-1:0]    r_mem [DEPTH];

    logic [N_CLIENTS-1:0] w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_any;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic                 w_in_range;
    logic [MEM_AW-1:0]    w_mem_idx;

    // Grant selection: locked owner only, otherwise round-robin starting after the pointer.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        if (!rst) begin
            if (r_state == StLocked) begin
                if (req[r_owner]) begin
                    w_gnt[r_owner] = 1'b1;
                    w_gnt_idx      = r_owner;
                    w_gnt_any      = 1'b1;
                end
            end else begin
                for (int unsigned k = 1; k <= N_CLIENTS; k++) begin
                    cand = IDX_W'((32'(r_ptr) + k) % N_CLIENTS);
                    if (!w_gnt_any && req[cand]) begin
                        w_gnt[cand] = 1'b1;
                        w_gnt_idx   = cand;
                        w_gnt_any   = 1'b1;
                    end
                end
            end
        end
    end

    // Route the granted client's command to the single memory port.
    always_comb begin
        w_we       = we[w_gnt_idx];
        w_addr     = addr[32'(w_gnt_idx) * ADDR_W +: ADDR_W];
        w_wdata    = wdata[32'(w_gnt_idx) * DATA_W +: DATA_W];
        w_in_range = (32'(w_addr) < DEPTH);
        w_mem_idx  = w_addr[MEM_AW-1:0];
    end

    // Memory array: contents survive reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (w_gnt_any && w_we && w_in_range) begin
            r_mem[w_mem_idx] <= w_wdata;
        end
    end

    // Arbiter FSM plus registered read response and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StArb;
            r_owner  <= '0;
            r_ptr    <= IDX_W'(N_CLIENTS - 1);
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt & ~we;
            r_err    <= w_in_range ? '0 : w_gnt;
            if (w_gnt_any && !w_we) begin
                r_rdata <= w_in_range ? r_mem[w_mem_idx] : '0;
            end
            unique case (r_state)
                StArb: begin
                    if (w_gnt_any) begin
                        r_ptr <= w_gnt_idx;
                        if (lock[w_gnt_idx]) begin
                            r_state <= StLocked;
                            r_owner <= w_gnt_idx;
                        end
                    end
                end
                StLocked: begin
                    // Pointer is frozen while locked; it already equals the owner.
                    if (!req[r_owner] || !lock[r_owner]) begin
                        r_state <= StArb;
                    end
                end
                default: r_state <= StArb;
            endcase
        end
    end

    assign gnt    = w_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign err    = r_err;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_grant_cnt [N_CLIENTS];

    // Per-client grant counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            if (rst) begin
                r_grant_cnt[i] <= '0;
            end else if (w_gnt[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
                r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < N_CLIENTS; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = r_grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_mem_arbiter_mp.sv
// Directed testbench for mem_arbiter_mp (4 clients, 8-bit address, 32-bit data, 200 words).
module tb_mem_arbiter_mp;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    err;
`ifdef MEM_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    int n_checks;
    int n_errors;

    mem_arbiter_mp #(
        .N_CLIENTS(N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (200)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .lock  (lock),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .rvalid(rvalid),
        .rdata (rdata),
        .err   (err)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_cl(input int i, input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]            = r;
        we[i]             = w;
        lock[i]           = l;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req  = '0;
        we   = '0;
        lock = '0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_errors++; $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        n_checks++;
        if (rvalid !== 4'b0000) begin
            n_errors++; $display("FAIL reset_rvalid: got %b want 0000", rvalid);
        end
        n_checks++;
        if (err !== 4'b0000) begin
            n_errors++; $display("FAIL reset_err: got %b want 0000", err);
        end
        n_checks++;
        if (rdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        next_cycle();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [7];
        logic [N-1:0] exp_v [7];
        exp_g[0] = 4'b0001; exp_v[0] = 4'b0000;
        exp_g[1] = 4'b0010; exp_v[1] = 4'b0001;
        exp_g[2] = 4'b0100; exp_v[2] = 4'b0010;
        exp_g[3] = 4'b1000; exp_v[3] = 4'b0100;
        exp_g[4] = 4'b0001; exp_v[4] = 4'b1000;
        exp_g[5] = 4'b0000; exp_v[5] = 4'b0001;
        exp_g[6] = 4'b0000; exp_v[6] = 4'b0000;
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < N; i++) set_cl(i, (c < 5), 1'b0, 1'b0, AW'(i + 1), '0);
            @(negedge clk);
            n_checks++;
            if (gnt !== exp_g[c]) begin
                n_errors++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, exp_g[c]);
            end
            n_checks++;
            if (rvalid !== exp_v[c]) begin
                n_errors++;
                $display("FAIL rr_rvalid c%0d: got %b want %b", c, rvalid, exp_v[c]);
            end
            n_checks++;
            if (err !== 4'b0000) begin
                n_errors++; $display("FAIL rr_err c%0d: got %b want 0000", c, err);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_read_after_write();
        idle();
        set_cl(2, 1'b1, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_errors++; $display("FAIL raw_wr_gnt: got %b want 0100", gnt);
        end
        next_cycle();
        idle();
        set_cl(1, 1'b1, 1'b0, 1'b0, 8'h10, '0);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_errors++; $display("FAIL raw_rd_gnt: got %b want 0010", gnt);
        end
        n_checks++;
        if (rvalid !== 4'b0000 || err !== 4'b0000) begin
            n_errors++; $display("FAIL raw_wr_resp: got rvalid %b err %b want 0000 0000", rvalid, err);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0010 || rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL raw_rd_data: got rvalid %b rdata %h want 0010 deadbeef", rvalid, rdata);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0000 || rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL raw_hold: got rvalid %b rdata %h want 0000 deadbeef", rvalid, rdata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        idle();
        set_cl(3, 1'b1, 1'b1, 1'b0, 8'h20, 32'hCAFE0003);
        next_cycle();
        idle();
        set_cl(0, 1'b1, 1'b1, 1'b0, 8'h21, 32'h0000A5A5);
        next_cycle();
        idle();
        set_cl(0, 1'b1, 1'b0, 1'b0, 8'h21, '0);
        set_cl(3, 1'b1, 1'b0, 1'b0, 8'h20, '0);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_errors++; $display("FAIL b2b_gnt_first: got %b want 1000", gnt);
        end
        next_cycle();
        req[3] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_errors++; $display("FAIL b2b_gnt_second: got %b want 0001", gnt);
        end
        n_checks++;
        if (rvalid !== 4'b1000 || rdata !== 32'hCAFE0003) begin
            n_errors++;
            $display("FAIL b2b_rd3: got rvalid %b rdata %h want 1000 cafe0003", rvalid, rdata);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0001 || rdata !== 32'h0000A5A5) begin
            n_errors++;
            $display("FAIL b2b_rd0: got rvalid %b rdata %h want 0001 0000a5a5", rvalid, rdata);
        end
        next_cycle();
    endtask

    task automatic test_lock();
        logic [N-1:0] exp_g [6];
        exp_g[0] = 4'b0010;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0010;
        exp_g[3] = 4'b0000;
        exp_g[4] = 4'b0100;
        exp_g[5] = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) set_cl(i, 1'b1, 1'b0, 1'b0, AW'(i + 40), '0);
            if (c < 3) lock[1] = 1'b1;
            if (c >= 3) req[1] = 1'b0;
            if (c == 5) idle();
            @(negedge clk);
            n_checks++;
            if (gnt !== exp_g[c]) begin
                n_errors++; $display("FAIL lock_gnt c%0d: got %b want %b", c, gnt, exp_g[c]);
            end
            if (c == 1) begin
                n_checks++;
                if (rvalid !== 4'b0010) begin
                    n_errors++; $display("FAIL lock_rvalid: got %b want 0010", rvalid);
                end
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_out_of_range();
        idle();
        set_cl(0, 1'b1, 1'b0, 1'b0, 8'h10, '0);
        next_cycle();
        set_cl(0, 1'b1, 1'b1, 1'b0, 8'd210, 32'h000000AA);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || rdata !== 32'hDEADBEEF || err !== 4'b0000) begin
            n_errors++;
            $display("FAIL oob_pre: got gnt %b rdata %h err %b want 0001 deadbeef 0000",
                     gnt, rdata, err);
        end
        next_cycle();
        set_cl(0, 1'b1, 1'b0, 1'b0, 8'd210, '0);
        @(negedge clk);
        n_checks++;
        if (err !== 4'b0001 || rvalid !== 4'b0000) begin
            n_errors++;
            $display("FAIL oob_wr_err: got err %b rvalid %b want 0001 0000", err, rvalid);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (err !== 4'b0001 || rvalid !== 4'b0001 || rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL oob_rd: got err %b rvalid %b rdata %h want 0001 0001 0",
                     err, rvalid, rdata);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (err !== 4'b0000) begin
            n_errors++; $display("FAIL oob_err_clear: got %b want 0000", err);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        idle();
        set_cl(2, 1'b1, 1'b0, 1'b1, 8'h10, '0);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_errors++; $display("FAIL rstmid_gnt_lock: got %b want 0100", gnt);
        end
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_cl(i, 1'b1, 1'b0, 1'b0, 8'h10, '0);
        lock[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_errors++; $display("FAIL rstmid_gnt_r1: got %b want 0000", gnt);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || rvalid !== 4'b0000 || err !== 4'b0000 || rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL rstmid_r2: got gnt %b rvalid %b err %b rdata %h want 0 0 0 0",
                     gnt, rvalid, err, rdata);
        end
        next_cycle();
        rst  = 1'b0;
        lock = '0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_errors++; $display("FAIL rstmid_release_gnt: got %b want 0001", gnt);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0001) begin
            n_errors++; $display("FAIL rstmid_release_rvalid: got %b want 0001", rvalid);
        end
        next_cycle();
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_cl(3, 1'b1, 1'b0, 1'b0, 8'h00, '0);
        repeat (100) next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant_cnt[63:48] !== 16'd100) begin
            n_errors++; $display("FAIL stats_cnt100: got %0d want 100", grant_cnt[63:48]);
        end
        repeat (69900) next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant_cnt[63:48] !== 16'hFFFF) begin
            n_errors++; $display("FAIL stats_sat: got %h want ffff", grant_cnt[63:48]);
        end
        n_checks++;
        if (grant_cnt[47:0] !== 48'h0) begin
            n_errors++; $display("FAIL stats_others: got %h want 0", grant_cnt[47:0]);
        end
        idle();
        next_cycle();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        req      = '0;
        we       = '0;
        lock     = '0;
        addr     = '0;
        wdata    = '0;
        test_reset();
        test_round_robin();
        test_read_after_write();
        test_back_to_back();
        test_lock();
        test_out_of_range();
        test_reset_mid();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_mp.md
Name: mem_arbiter_mp

Overview:
- Parametrised multi-client memory block: N requesters share one single-port on-chip memory through a round-robin arbiter.
- Generalises the writer/reader/memory split: each client port can issue reads or writes, has a valid/grant handshake, and can lock the arbiter for bursts.
- Sits between client engines and local storage; one memory access per clock.

Parameters:
- N_CLIENTS, 4, number of requester ports (2..16).
- ADDR_W, 8, address width per client.
- DATA_W, 32, data width.
- DEPTH, 256, memory words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_CLIENTS  per-client access request.
- we  input  N_CLIENTS  1 = write, 0 = read; qualified by req.
- lock  input  N_CLIENTS  hold the grant for the following cycle.
- addr  input  N_CLIENTS*ADDR_W  flattened addresses; client i at [i*ADDR_W +: ADDR_W].
- wdata  input  N_CLIENTS*DATA_W  flattened write data.
- gnt  output  N_CLIENTS  one-hot grant; the access completes in the cycle req&gnt is high.
- rvalid  output  N_CLIENTS  one-hot; read data valid for client i.
- rdata  output  DATA_W  shared read-data bus.
- err  output  N_CLIENTS  one-cycle pulse; the access granted last cycle was out of range.

Behaviour:
- Interface: clk and rst only. Reset is synchronous and active-high. No asynchronous logic.
- Reset (rst high at an edge): rvalid=0, err=0, rdata=0, lock state cleared, RR pointer=N_CLIENTS-1 so client 0 has top priority. gnt is forced to 0 while rst is high. Memory contents are not reset.
- Arbitration is combinational within the cycle. Priority starts at (pointer+1) mod N and wraps.
- gnt is one-hot or zero. gnt[i]=1 only if req[i]=1.
- On each grant, pointer <= granted index.
- Clients hold addr, we and wdata stable while req is high and gnt is low. Deasserting req before grant is permitted; the request is simply dropped.
- FSM states: ARB and LOCKED.
  - ARB: normal round-robin.
  - If the granted client also has lock[i]=1, next state is LOCKED with owner=i.
  - LOCKED: only the owner can be granted; other requests wait. The pointer is not updated.
  - LOCKED exits to ARB at the edge where the owner has req=0 or lock=0. That cycle's grant still follows LOCKED rules.
- Write: mem[addr] <= wdata at the edge ending the grant cycle.
- Read: mem[addr] is sampled at that edge. rvalid[i]=1 and rdata=data in the next cycle, giving 1-cycle latency.
- Back-to-back reads from different clients produce consecutive rvalid pulses.
- Read-after-write to the same address in consecutive cycles returns the new data.
- rdata holds its last value when rvalid=0.
- Out-of-range access (addr >= DEPTH):
  - Write is dropped.
  - Read returns rdata=0 with rvalid=1.
  - err[i] pulses in the rvalid cycle (the cycle after the grant) for both reads and writes.
- rst asserted mid-operation: any pending rvalid or err is cancelled. Lock is released.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds output port grant_cnt [N_CLIENTS*16-1:0], one 16-bit per-client counter. Each counter increments on each grant, saturates at 16'hFFFF, and resets to 0 on rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then req=4'b1111 held, all reads → grants in order 0,1,2,3,0. Each rvalid follows its grant by exactly 1 cycle.
- Client 2 writes 0xDEADBEEF to addr 0x10. Next cycle client 1 reads 0x10 → rvalid[1]=1 next cycle, rdata=0xDEADBEEF.
- Client 1 asserts req+lock for 3 cycles while req=4'b1111 → gnt=4'b0010 for 3 cycles. After lock drops, the next grant goes to client 2.
- DEPTH=200: client 0 writes 0xAA to addr 210, then reads addr 210 → err[0] pulses in the cycle after each grant. The read returns rdata=0. mem[210 mod 256] is not created.
- rst asserted in the cycle after a read grant → rvalid=0, gnt=0 during rst. After release, client 0 is granted first.
- With MEM_ARB_STATS_EN: 70000 consecutive grants to client 3 → grant_cnt[63:48]=16'hFFFF. Other counters stay 0.
